// File: rtl/pkt_detect_mc.sv
// Multi-channel packet-envelope detector: sync, min-on qualify, hangover bridge, start/end events.
// Optional packet-length measurement is built when PKT_DECT_LEN_EN is defined.
module pkt_detect_mc #(
    parameter int NUM_CH     = 4,
    parameter int MIN_ON_CYC = 4,
    parameter int HANG_CYC   = 400,
    parameter int CNT_W      = 16,
    parameter int LEN_W      = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH-1:0]       dect_in,
    output logic [NUM_CH-1:0]       det_out,
    output logic                    any_det,
    output logic [NUM_CH-1:0]       pkt_start,
    output logic [NUM_CH-1:0]       pkt_end,
    output logic [NUM_CH*LEN_W-1:0] pkt_len,
    output logic [NUM_CH-1:0]       pkt_len_vld
);

    // IDLE: waiting | ARM: qualifying min-on | ACTIVE: carrier present | HANG: bridging a gap
    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_ACTIVE, ST_HANG} state_t;

    localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(MIN_ON_CYC - 1);
    localparam logic [CNT_W-1:0] HANG_LAST = CNT_W'(HANG_CYC - 1);

    logic [NUM_CH-1:0] s1_q, s1_d, s2_q, s2_d;
    state_t            state_q [NUM_CH];
    state_t            state_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];
    logic [NUM_CH-1:0] det_q, det_d, start_q, start_d, end_q, end_d;
    logic              any_q, any_d;

    always_comb begin
        s1_d  = dect_in;
        s2_d  = s1_q;
        any_d = |det_q;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            start_d[i] = 1'b0;
            end_d[i]   = 1'b0;
            if (!ch_en[i]) begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (s2_q[i]) begin
                            if (MIN_ON_CYC == 1) begin
                                state_d[i] = ST_ACTIVE;
                                start_d[i] = 1'b1;
                                cnt_d[i]   = '0;
                            end else begin
                                state_d[i] = ST_ARM;
                                cnt_d[i]   = CNT_W'(1);
                            end
                        end
                    end
                    ST_ARM: begin
                        if (!s2_q[i]) begin
                            state_d[i] = ST_IDLE;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] == ARM_LAST) begin
                            state_d[i] = ST_ACTIVE;
                            start_d[i] = 1'b1;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    ST_ACTIVE: begin
                        if (!s2_q[i]) begin
                            state_d[i] = ST_HANG;
                            cnt_d[i]   = '0;
                        end
                    end
                    ST_HANG: begin
                        // Carrier returning before the exit edge keeps the same packet alive.
                        if (s2_q[i]) begin
                            state_d[i] = ST_ACTIVE;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] == HANG_LAST) begin
                            state_d[i] = ST_IDLE;
                            end_d[i]   = 1'b1;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
            det_d[i] = (state_d[i] == ST_ACTIVE) || (state_d[i] == ST_HANG);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            det_q   <= '0;
            start_q <= '0;
            end_q   <= '0;
            any_q   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            det_q   <= det_d;
            start_q <= start_d;
            end_q   <= end_d;
            any_q   <= any_d;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign det_out   = det_q;
    assign any_det   = any_q;
    assign pkt_start = start_q;
    assign pkt_end   = end_q;

`ifdef PKT_DECT_LEN_EN
    logic [LEN_W-1:0]  len_q  [NUM_CH];
    logic [LEN_W-1:0]  len_d  [NUM_CH];
    logic [LEN_W-1:0]  hold_q [NUM_CH];
    logic [LEN_W-1:0]  hold_d [NUM_CH];
    logic [NUM_CH-1:0] vld_q, vld_d;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            len_d[i]  = len_q[i];
            hold_d[i] = hold_q[i];
            vld_d[i]  = 1'b0;
            if (!ch_en[i]) begin
                len_d[i] = '0;
            end else if (start_d[i]) begin
                len_d[i] = LEN_W'(1);
            end else if (end_d[i]) begin
                hold_d[i] = len_q[i];
                vld_d[i]  = 1'b1;
                len_d[i]  = '0;
            end else if (((state_q[i] == ST_ACTIVE) || (state_q[i] == ST_HANG)) &&
                         (len_q[i] != {LEN_W{1'b1}})) begin
                len_d[i] = len_q[i] + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                len_q[i]  <= '0;
                hold_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < NUM_CH; i++) begin
                len_q[i]  <= len_d[i];
                hold_q[i] <= hold_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_len
        assign pkt_len[g*LEN_W +: LEN_W] = hold_q[g];
    end
    assign pkt_len_vld = vld_q;
`else
    assign pkt_len     = '0;
    assign pkt_len_vld = '0;
`endif

endmodule

// File: tb/tb_pkt_detect_mc.sv
// Directed bench for pkt_detect_mc: default 4-channel instance plus a 1-channel
// MIN_ON_CYC=1 / LEN_W=8 instance for the fast-start and saturation cases.
module tb_pkt_detect_mc;

`ifdef PKT_DECT_LEN_EN
    localparam int LEN_ON = 1;
`else
    localparam int LEN_ON = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ch_en, dect_in, det_out, pkt_start, pkt_end, pkt_len_vld;
    logic        any_det;
    logic [79:0] pkt_len;

    logic        b_en, b_dect, b_det, b_any, b_start, b_end, b_vld;
    logic [7:0]  b_len;

    int tests = 0;
    int fails = 0;

    always #25 clk = ~clk;

    pkt_detect_mc #(.NUM_CH(4), .MIN_ON_CYC(4), .HANG_CYC(400), .CNT_W(16), .LEN_W(20)) u_dut (
        .clk(clk), .rst(rst), .ch_en(ch_en), .dect_in(dect_in), .det_out(det_out),
        .any_det(any_det), .pkt_start(pkt_start), .pkt_end(pkt_end),
        .pkt_len(pkt_len), .pkt_len_vld(pkt_len_vld)
    );

    pkt_detect_mc #(.NUM_CH(1), .MIN_ON_CYC(1), .HANG_CYC(8), .CNT_W(8), .LEN_W(8)) u_dut_b (
        .clk(clk), .rst(rst), .ch_en(b_en), .dect_in(b_dect), .det_out(b_det),
        .any_det(b_any), .pkt_start(b_start), .pkt_end(b_end),
        .pkt_len(b_len), .pkt_len_vld(b_vld)
    );

    // Cumulative event monitors, sampled mid-cycle.
    int   start_cnt [4];
    int   end_cnt   [4];
    int   det_cnt   [4];
    int   vld_cnt   [4];
    int   both_cnt  [4];
    int   asym_cnt  = 0;
    int   any_err   = 0;
    int   b_det_cnt = 0;
    int   b_end_cnt = 0;
    logic prev_or   = 1'b0;

    initial begin
        for (int i = 0; i < 4; i++) begin
            start_cnt[i] = 0; end_cnt[i] = 0; det_cnt[i] = 0; vld_cnt[i] = 0; both_cnt[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (pkt_start[i] === 1'b1) start_cnt[i]++;
            if (pkt_end[i] === 1'b1) end_cnt[i]++;
            if (det_out[i] === 1'b1) det_cnt[i]++;
            if (pkt_len_vld[i] === 1'b1) vld_cnt[i]++;
            if ((pkt_len_vld[i] & pkt_end[i]) === 1'b1) both_cnt[i]++;
        end
        if (!(pkt_start inside {4'h0, 4'hF}) || !(pkt_end inside {4'h0, 4'hF}) ||
            !(det_out inside {4'h0, 4'hF}) || !(pkt_len_vld inside {4'h0, 4'hF}))
            asym_cnt++;
        if (any_det !== prev_or) any_err++;
        prev_or = |det_out;
        if (b_det === 1'b1) b_det_cnt++;
        if (b_end === 1'b1) b_end_cnt++;
    end

    int base_start [4];
    int base_end   [4];
    int base_det   [4];
    int base_vld   [4];
    int base_both  [4];
    int base_b_det, base_b_end;

    task automatic snap();
        for (int i = 0; i < 4; i++) begin
            base_start[i] = start_cnt[i]; base_end[i] = end_cnt[i]; base_det[i] = det_cnt[i];
            base_vld[i] = vld_cnt[i]; base_both[i] = both_cnt[i];
        end
        base_b_det = b_det_cnt;
        base_b_end = b_end_cnt;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Checks start/end/det-cycles/vld/len for one channel since the last snap.
    task automatic chk_pkt(input string tag, input int ch, input int n_pkt, input int det_cyc,
                           input int len);
        chk({tag, "_start"}, 64'(start_cnt[ch] - base_start[ch]), 64'(n_pkt));
        chk({tag, "_end"}, 64'(end_cnt[ch] - base_end[ch]), 64'(n_pkt));
        chk({tag, "_detcyc"}, 64'(det_cnt[ch] - base_det[ch]), 64'(det_cyc));
        chk({tag, "_vld"}, 64'(vld_cnt[ch] - base_vld[ch]), 64'(n_pkt * LEN_ON));
        chk({tag, "_vld_with_end"}, 64'(both_cnt[ch] - base_both[ch]), 64'(n_pkt * LEN_ON));
        chk({tag, "_len"}, 64'(pkt_len[ch*20 +: 20]), 64'(len * LEN_ON));
    endtask

    initial begin
        rst = 1'b1; ch_en = 4'hF; dect_in = 4'h0; b_en = 1'b1; b_dect = 1'b0;
        tick(3);
        chk("rst_det_out", 64'(det_out), 64'd0);
        chk("rst_any_det", 64'(any_det), 64'd0);
        chk("rst_pkt_start", 64'(pkt_start), 64'd0);
        chk("rst_pkt_end", 64'(pkt_end), 64'd0);
        chk("rst_pkt_len", 64'(pkt_len), 64'd0);
        chk("rst_pkt_len_vld", 64'(pkt_len_vld), 64'd0);
        rst = 1'b0;
        tick(10);
        chk("idle_outputs", 64'({det_out, any_det, pkt_start, pkt_end, pkt_len_vld}), 64'd0);
        chk("idle_pkt_len", 64'(pkt_len), 64'd0);

        // 3-cycle glitch on ch0 is rejected
        snap();
        dect_in[0] = 1'b1; tick(3); dect_in[0] = 1'b0; tick(20);
        chk("glitch_start", 64'(start_cnt[0] - base_start[0]), 64'd0);
        chk("glitch_end", 64'(end_cnt[0] - base_end[0]), 64'd0);
        chk("glitch_det", 64'(det_cnt[0] - base_det[0]), 64'd0);

        // 100-cycle packet on ch0: start after edge t+5, length 497
        snap();
        dect_in[0] = 1'b1;
        tick(5);
        chk("single_det_pre", 64'(det_out[0]), 64'd0);
        tick(1);
        chk("single_det_rise", 64'(det_out[0]), 64'd1);
        chk("single_start_pulse", 64'(pkt_start[0]), 64'd1);
        tick(94); dect_in[0] = 1'b0; tick(450);
        chk_pkt("single", 0, 1, 497, 497);

        // ch1 gap of 300 bridged
        snap();
        dect_in[1] = 1'b1; tick(50); dect_in[1] = 1'b0; tick(300);
        dect_in[1] = 1'b1; tick(50); dect_in[1] = 1'b0; tick(450);
        chk_pkt("gap300", 1, 1, 797, 797);
        chk("gap300_ch0_quiet", 64'(start_cnt[0] - base_start[0]), 64'd0);

        // gap of exactly HANG_CYC is still bridged
        snap();
        dect_in[1] = 1'b1; tick(50); dect_in[1] = 1'b0; tick(400);
        dect_in[1] = 1'b1; tick(50); dect_in[1] = 1'b0; tick(450);
        chk_pkt("gap400", 1, 1, 897, 897);

        // gap of 420 splits into two packets
        snap();
        dect_in[1] = 1'b1; tick(50); dect_in[1] = 1'b0; tick(420);
        dect_in[1] = 1'b1; tick(50); dect_in[1] = 1'b0; tick(450);
        chk_pkt("gap420", 1, 2, 894, 447);

        // all channels identical, same-cycle events
        snap();
        asym_cnt = 0;
        dect_in = 4'hF; tick(100); dect_in = 4'h0; tick(450);
        for (int i = 0; i < 4; i++) chk_pkt($sformatf("simul_ch%0d", i), i, 1, 497, 497);
        chk("simul_same_cycle", 64'(asym_cnt), 64'd0);

        // abort ch2 mid-packet, ch3 runs to completion
        snap();
        dect_in[2] = 1'b1; dect_in[3] = 1'b1;
        tick(30);
        ch_en[2] = 1'b0;
        tick(1);
        chk("abort_det2_low", 64'(det_out[2]), 64'd0);
        chk("abort_det3_high", 64'(det_out[3]), 64'd1);
        tick(39); dect_in[2] = 1'b0; dect_in[3] = 1'b0; tick(450);
        chk("abort_end2", 64'(end_cnt[2] - base_end[2]), 64'd0);
        chk("abort_vld2", 64'(vld_cnt[2] - base_vld[2]), 64'd0);
        chk("abort_detcyc2", 64'(det_cnt[2] - base_det[2]), 64'd25);
        chk("abort_len2_held", 64'(pkt_len[40 +: 20]), 64'(497 * LEN_ON));
        chk_pkt("abort_ch3", 3, 1, 467, 467);
        ch_en[2] = 1'b1;
        tick(5);

        chk("any_det_tracks", 64'(any_err), 64'd0);

        // MIN_ON_CYC=1 start timing and 8-bit length saturation
        snap();
        b_dect = 1'b1;
        tick(2);
        chk("b_det_pre", 64'(b_det), 64'd0);
        tick(1);
        chk("b_det_rise", 64'(b_det), 64'd1);
        chk("b_start_pulse", 64'(b_start), 64'd1);
        tick(297); b_dect = 1'b0; tick(20);
        chk("b_detcyc", 64'(b_det_cnt - base_b_det), 64'd308);
        chk("b_end", 64'(b_end_cnt - base_b_end), 64'd1);
        chk("b_len_sat", 64'(b_len), 64'(255 * LEN_ON));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
